imem_loader: RTL

Byte-stream program loader that writes the instruction memory the processor fetches from. It receives a framed program image: 16-bit word count, big-endian 32-bit instruction words, and an XOR checksum byte. It holds the processor in reset while loading and releases it only after a verified load. It sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_word_assembler.sv | 36 +++
 rtl/imem_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int CNT_W = 16;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  function automatic logic is_ready_state(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  function automatic logic is_rest_state(state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs big-endian bytes into 32-bit words and keeps the running XOR checksum.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o,
  output logic [7:0]  csum_o
);

  logic [23:0] shift_q;
  logic [1:0]  lane_q;
  logic [7:0]  csum_q;

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      shift_q <= '0;
      lane_q  <= LANE_FIRST;
      csum_q  <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      lane_q  <= lane_q + 2'd1;
      csum_q  <= csum_q ^ byte_i;
    end
  end

  // The word is complete in the same cycle its last byte is on the bus.
  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = byte_en_i && (lane_q == LANE_LAST);
  assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset
// until an image with a matching XOR checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   words_q;
  logic [CNT_W-1:0]   len_rx;
  logic               s_ready_q, imem_we_q, cpu_rst_n_q, busy_q, done_q, error_q;
  logic [31:0]        addr_q, wdata_q;
  logic               accept, load_start, data_byte;
  logic [31:0]        asm_word;
  logic               asm_word_ready;
  logic [7:0]         asm_csum;

  assign accept     = s_valid && s_ready_q;
  assign load_start = start && is_rest_state(state_q);
  assign data_byte  = accept && (state_q == ST_DATA);
  assign len_rx     = {count_q[15:8], s_data};

  imem_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (load_start),
    .byte_en_i    (data_byte),
    .byte_i       (s_data),
    .word_o       (asm_word),
    .word_ready_o (asm_word_ready),
    .csum_o       (asm_csum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_rx > 16'(DEPTH))  state_d = ST_ERR;
          else if (len_rx == '0)    state_d = ST_CSUM;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA:  if (asm_word_ready) state_d = ST_WRITE;
      ST_WRITE: state_d = ((words_q + 16'd1) == count_q) ? ST_CSUM : ST_DATA;
      ST_CSUM:  if (accept) state_d = (s_data == asm_csum) ? ST_DONE : ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      words_q     <= '0;
      s_ready_q   <= 1'b0;
      imem_we_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= is_ready_state(state_d);
      busy_q      <= !is_rest_state(state_d);
      done_q      <= (state_d == ST_DONE);
      error_q     <= (state_d == ST_ERR);
      cpu_rst_n_q <= (state_d == ST_DONE);
      imem_we_q   <= (state_d == ST_WRITE);

      if (load_start) begin
        count_q <= '0;
        words_q <= '0;
      end
      if (accept && state_q == ST_LEN_HI) count_q[15:8] <= s_data;
      if (accept && state_q == ST_LEN_LO) count_q[7:0]  <= s_data;

      if (state_q == ST_DATA && state_d == ST_WRITE) begin
        addr_q  <= BASE_ADDR + 32'({words_q, 2'b00});
        wdata_q <= asm_word;
      end
      if (state_q == ST_WRITE) words_q <= words_q + 16'd1;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
